// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module  : serial_subtractor_pkg
// Brief   : Shared state encoding, default width and counter sizing helper.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

   typedef logic [1:0] state_t;

   localparam state_t C_ST_IDLE  = 2'd0;
   localparam state_t C_ST_SHIFT = 2'd1;
   localparam state_t C_ST_DONE  = 2'd2;

   localparam int C_WIDTH_DEFAULT = 8;

   // Bit-counter width; never narrower than one bit, even for WIDTH=1.
   function automatic int SUB_CNT_W(input int width);
      int w;
      w = $clog2(width);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_fs.sv
// ============================================================================
// Module  : Full_Subtractor
// Brief   : Gate-level one-bit full subtractor, D = A-B-C with borrow out Bo.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module Full_Subtractor (
   input  logic A,
   input  logic B,
   input  logic C,
   output logic D,
   output logic Bo
);

   assign D  = A ^ B ^ C;
   assign Bo = (~A & B) | (~A & C) | (B & C);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module  : serial_subtractor
// Brief   : Bit-serial unsigned a-b, LSB first, one Full_Subtractor reused.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = C_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int             CNT_W      = SUB_CNT_W(WIDTH);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_sa;
   logic [WIDTH-1:0]   r_sb;
   logic [WIDTH-1:0]   r_sd;
   logic               r_br;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_diff;
   logic               r_borrow;

   logic               w_d;
   logic               w_bo;
   logic [WIDTH-1:0]   w_sd_next;

   Full_Subtractor u_fs (
      .A  (r_sa[0]),
      .B  (r_sb[0]),
      .C  (r_br),
      .D  (w_d),
      .Bo (w_bo)
   );

   // New difference bit enters at the MSB; written this way so WIDTH=1 needs no special case.
   assign w_sd_next = WIDTH'({w_d, r_sd} >> 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= C_ST_IDLE;
         r_sa     <= '0;
         r_sb     <= '0;
         r_sd     <= '0;
         r_br     <= 1'b0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else begin
         case (r_state)
            C_ST_IDLE: begin
               if (start) begin
                  r_sa    <= a;
                  r_sb    <= b;
                  r_br    <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= C_ST_SHIFT;
               end
            end
            C_ST_SHIFT: begin
               r_sa  <= r_sa >> 1;
               r_sb  <= r_sb >> 1;
               r_sd  <= w_sd_next;
               r_br  <= w_bo;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == C_CNT_LAST) begin
                  r_state  <= C_ST_DONE;
                  r_diff   <= w_sd_next;
                  r_borrow <= w_bo;
               end
            end
            C_ST_DONE: r_state <= C_ST_IDLE;
            default:   r_state <= C_ST_IDLE;
         endcase
      end
   end

   assign busy       = (r_state == C_ST_SHIFT) || (r_state == C_ST_DONE);
   assign done       = (r_state == C_ST_DONE);
   assign diff       = r_diff;
   assign borrow_out = r_borrow;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module  : tb_serial_subtractor
// Brief   : Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;

   logic         start1;
   logic [0:0]   a1;
   logic [0:0]   b1;
   logic         busy1;
   logic         done1;
   logic [0:0]   diff1;
   logic         bo1;

   int n_pass  = 0;
   int n_total = 0;
   logic [W-1:0] last_diff;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
   );

   // Reference: plain modular arithmetic and unsigned compare.
   function automatic logic [W-1:0] ref_diff(input int x, input int y);
      return W'((x - y + 256) % 256);
   endfunction

   function automatic logic ref_borrow(input int x, input int y);
      return (x < y);
   endfunction

   // Issues one start, then drives pa/pb after the accepting edge; reports what it saw.
   task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic [W-1:0] pa, input logic [W-1:0] pb,
                        output logic [W-1:0] rd, output logic rb,
                        output logic [W-1:0] mid_diff,
                        output int done_at, output int busy_n, output int done_n);
      @(negedge clk);
      start = 1'b1; a = oa; b = ob;
      @(negedge clk);
      start = 1'b0; a = pa; b = pb;
      done_at = -1; busy_n = 0; done_n = 0; rd = 'x; rb = 1'bx; mid_diff = 'x;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 1) mid_diff = diff;
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (done_at < 0) begin
               done_at = i; rd = diff; rb = borrow_out;
            end
         end
         if (!busy) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; start1 = 1'b1;
      a = 8'hFF; b = 8'h00; a1 = 1'b1; b1 = 1'b0;
      repeat (3) @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
      n_total++; if (diff !== 8'h00) $display("FAIL reset_diff got %h exp 00", diff); else n_pass++;
      n_total++; if (borrow_out !== 1'b0) $display("FAIL reset_borrow got %b exp 0", borrow_out); else n_pass++;
      n_total++; if (busy1 !== 1'b0) $display("FAIL reset_busy1 got %b exp 0", busy1); else n_pass++;
      n_total++; if (done1 !== 1'b0) $display("FAIL reset_done1 got %b exp 0", done1); else n_pass++;
      n_total++; if (diff1 !== 1'b0) $display("FAIL reset_diff1 got %b exp 0", diff1); else n_pass++;
      n_total++; if (bo1 !== 1'b0) $display("FAIL reset_borrow1 got %b exp 0", bo1); else n_pass++;
      start = 1'b0; start1 = 1'b0;
      rst = 1'b0;
      last_diff = '0;
   endtask

   task automatic test_directed();
      logic [W-1:0] va [3] = '{8'h5A, 8'h00, 8'hFF};
      logic [W-1:0] vb [3] = '{8'h3C, 8'h01, 8'hFF};
      logic [W-1:0] rd, md, ed;
      logic rb, eb;
      int dat, bn, dn;
      for (int t = 0; t < 3; t++) begin
         ed = ref_diff(int'(va[t]), int'(vb[t]));
         eb = ref_borrow(int'(va[t]), int'(vb[t]));
         do_op(va[t], vb[t], 8'($urandom), 8'($urandom), rd, rb, md, dat, bn, dn);
         n_total++; if (rd !== ed) $display("FAIL dir_diff[%0d] got %h exp %h", t, rd, ed); else n_pass++;
         n_total++; if (rb !== eb) $display("FAIL dir_borrow[%0d] got %b exp %b", t, rb, eb); else n_pass++;
         n_total++; if (dat !== W) $display("FAIL dir_latency[%0d] got %0d exp %0d", t, dat, W); else n_pass++;
         // busy spans edges k..k+W+1, i.e. W+1 sampled cycles
         n_total++; if (bn !== W + 1) $display("FAIL dir_busy_cycles[%0d] got %0d exp %0d", t, bn, W + 1); else n_pass++;
         n_total++; if (dn !== 1) $display("FAIL dir_done_count[%0d] got %0d exp 1", t, dn); else n_pass++;
         n_total++; if (md !== last_diff) $display("FAIL dir_diff_held[%0d] got %h exp %h", t, md, last_diff); else n_pass++;
         last_diff = ed;
      end
   endtask

   task automatic test_random();
      logic [W-1:0] x, y, rd, md;
      logic rb;
      int dat, bn, dn;
      for (int t = 0; t < 16; t++) begin
         x = 8'($urandom);
         y = 8'($urandom);
         do_op(x, y, 8'($urandom), 8'($urandom), rd, rb, md, dat, bn, dn);
         n_total++; if (rd !== ref_diff(int'(x), int'(y)))
            $display("FAIL rnd_diff a=%h b=%h got %h exp %h", x, y, rd, ref_diff(int'(x), int'(y))); else n_pass++;
         n_total++; if (rb !== ref_borrow(int'(x), int'(y)))
            $display("FAIL rnd_borrow a=%h b=%h got %b exp %b", x, y, rb, ref_borrow(int'(x), int'(y))); else n_pass++;
         n_total++; if (dat !== W) $display("FAIL rnd_latency got %0d exp %0d", dat, W); else n_pass++;
         last_diff = ref_diff(int'(x), int'(y));
      end
   endtask

   task automatic test_change_inputs();
      logic [W-1:0] rd, md;
      logic rb;
      int dat, bn, dn;
      do_op(8'h3C, 8'hC3, 8'hAA, 8'h55, rd, rb, md, dat, bn, dn);
      n_total++; if (rd !== ref_diff(8'h3C, 8'hC3)) $display("FAIL chg_diff got %h exp %h", rd, ref_diff(8'h3C, 8'hC3)); else n_pass++;
      n_total++; if (rb !== 1'b1) $display("FAIL chg_borrow got %b exp 1", rb); else n_pass++;
      last_diff = ref_diff(8'h3C, 8'hC3);
   endtask

   task automatic test_hold_start();
      int idx [$];
      @(negedge clk);
      start = 1'b1; a = 8'h80; b = 8'h7F;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (done) begin
            idx.push_back(i);
            n_total++; if (diff !== 8'h01) $display("FAIL hold_diff at %0d got %h exp 01", i, diff); else n_pass++;
            n_total++; if (borrow_out !== 1'b0) $display("FAIL hold_borrow at %0d got %b exp 0", i, borrow_out); else n_pass++;
         end
         if (i == 24) start = 1'b0;
      end
      n_total++; if (idx.size() !== 3) $display("FAIL hold_done_count got %0d exp 3", idx.size()); else n_pass++;
      for (int j = 1; j < idx.size(); j++) begin
         n_total++; if (idx[j] - idx[j-1] !== W + 2)
            $display("FAIL hold_spacing[%0d] got %0d exp %0d", j, idx[j] - idx[j-1], W + 2); else n_pass++;
      end
      last_diff = 8'h01;
   endtask

   task automatic test_rst_mid();
      logic [W-1:0] rd, md;
      logic rb;
      int dat, bn, dn, seen;
      do_op(8'h00, 8'h01, 8'h00, 8'h00, rd, rb, md, dat, bn, dn);
      n_total++; if (rb !== 1'b1) $display("FAIL rst_pre_borrow got %b exp 1", rb); else n_pass++;
      @(negedge clk);
      start = 1'b1; a = 8'h10; b = 8'h20;
      @(negedge clk);
      start = 1'b0;
      seen = done ? 1 : 0;
      repeat (3) begin
         @(negedge clk);
         if (done) seen++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", busy); else n_pass++;
      n_total++; if (diff !== 8'h00) $display("FAIL rst_mid_diff got %h exp 00", diff); else n_pass++;
      n_total++; if (borrow_out !== 1'b0) $display("FAIL rst_mid_borrow got %b exp 0", borrow_out); else n_pass++;
      for (int i = 0; i < 12; i++) begin
         if (done) seen++;
         @(negedge clk);
      end
      n_total++; if (seen !== 0) $display("FAIL rst_mid_no_done got %0d exp 0", seen); else n_pass++;
      last_diff = '0;
      do_op(8'h10, 8'h20, 8'h00, 8'h00, rd, rb, md, dat, bn, dn);
      n_total++; if (rd !== 8'hF0) $display("FAIL rst_after_diff got %h exp F0", rd); else n_pass++;
      n_total++; if (rb !== 1'b1) $display("FAIL rst_after_borrow got %b exp 1", rb); else n_pass++;
      n_total++; if (md !== 8'h00) $display("FAIL rst_after_held got %h exp 00", md); else n_pass++;
      last_diff = 8'hF0;
   endtask

   task automatic test_width1();
      int dat;
      logic rd, rb;
      for (int x = 0; x < 2; x++) begin
         for (int y = 0; y < 2; y++) begin
            @(negedge clk);
            start1 = 1'b1; a1 = 1'(x); b1 = 1'(y);
            @(negedge clk);
            start1 = 1'b0; a1 = 1'(1 - x); b1 = 1'(1 - y);
            dat = -1; rd = 1'bx; rb = 1'bx;
            for (int i = 0; i < 10; i++) begin
               if (i > 0) @(negedge clk);
               if (done1 && dat < 0) begin
                  dat = i; rd = diff1; rb = bo1;
               end
            end
            n_total++; if (rd !== 1'((x - y + 2) % 2)) $display("FAIL w1_diff a=%0d b=%0d got %b exp %0d", x, y, rd, (x - y + 2) % 2); else n_pass++;
            n_total++; if (rb !== (x < y)) $display("FAIL w1_borrow a=%0d b=%0d got %b exp %0d", x, y, rb, (x < y)); else n_pass++;
            n_total++; if (dat !== 1) $display("FAIL w1_latency a=%0d b=%0d got %0d exp 1", x, y, dat); else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_change_inputs();
      test_hold_start();
      test_rst_mid();
      test_width1();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d checked", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
